hermes_input_buffer: RTL and testbench

- Per-port input stage of the Hermes router. Sits directly downstream of a link's datain side.
- Accepts flits under credit-based flow control and stores them in a FIFO.
- Frames each packet (header, size, payload) and requests a route from switch control.
- Once the route is granted, streams the whole packet to the crossbar with a valid/ack handshake.

---
 rtl/hermes_pkg.sv | 17 +
 rtl/hermes_fifo.sv | 67 ++++++
 rtl/hermes_input_buffer.sv | 113 +++++++++++
 tb/tb_hermes_input_buffer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hermes_pkg.sv
// Shared types for the Hermes router input stage: flit type and the
// packet-framing state encoding.
package hermes_pkg;

    localparam int FLIT_WIDTH = 16;

    typedef logic [FLIT_WIDTH-1:0] flit_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_HDR  = 3'd2,
        S_SIZE = 3'd3,
        S_PAY  = 3'd4
    } ib_state_t;

endpackage

// File: rtl/hermes_fifo.sv
// Synchronous flit FIFO with registered occupancy count. Writes when full and
// reads when empty are dropped internally, so callers cannot corrupt state.
module hermes_fifo
    import hermes_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     wr_i,
    input  flit_t                    wr_data_i,
    input  logic                     rd_i,
    output logic                     full_o,
    output logic                     empty_o,
    output flit_t                    head_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    flit_t          mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [AW:0]    count_q;
    logic [AW:0]    count_d;
    logic           wr_en;
    logic           rd_en;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    assign wr_en = wr_i && !full_o;
    assign rd_en = rd_i && !empty_o;

    always_comb begin
        count_d = count_q;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage is cleared on reset so the head reads as zero while empty.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/hermes_input_buffer.sv
// Hermes per-port input stage: buffers flits under credit flow control, frames
// each packet (header, size, payload) and streams it once the route is granted.
module hermes_input_buffer
    import hermes_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     rx,
    input  flit_t                    data_in,
    output logic                     credit_o,
    output logic                     h,
    input  logic                     ack_h,
    output logic                     data_av,
    output flit_t                    data_out,
    input  logic                     data_ack,
    output logic                     sender,
    output ib_state_t                dbg_state_o,
    output logic [$clog2(DEPTH):0]   dbg_count_o
);

    // Handshake: a flit moves downstream on a rising edge where data_av and
    // data_ack are both high; upstream may write on any edge with credit_o high.

    ib_state_t  state_q;
    logic       h_q;
    logic       sender_q;
    flit_t      pay_cnt_q;
    logic       full;
    logic       empty;
    logic       pop;
    logic [$clog2(DEPTH):0] count;

    hermes_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i     (clock),
        .rst_ni    (reset),
        .wr_i      (rx),
        .wr_data_i (data_in),
        .rd_i      (pop),
        .full_o    (full),
        .empty_o   (empty),
        .head_o    (data_out),
        .count_o   (count)
    );

    assign credit_o    = !full;
    assign data_av     = sender_q && !empty;
    assign pop         = data_av && data_ack;
    assign h           = h_q;
    assign sender      = sender_q;
    assign dbg_state_o = state_q;
    assign dbg_count_o = count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            h_q       <= 1'b0;
            sender_q  <= 1'b0;
            pay_cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!empty) begin
                        state_q <= S_REQ;
                        h_q     <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (ack_h) begin
                        state_q  <= S_HDR;
                        h_q      <= 1'b0;
                        sender_q <= 1'b1;
                    end
                end
                S_HDR: begin
                    if (pop) begin
                        state_q <= S_SIZE;
                    end
                end
                S_SIZE: begin
                    // The size flit is the number of payload flits that follow.
                    if (pop) begin
                        pay_cnt_q <= data_out;
                        if (data_out == '0) begin
                            state_q  <= S_IDLE;
                            sender_q <= 1'b0;
                        end else begin
                            state_q <= S_PAY;
                        end
                    end
                end
                S_PAY: begin
                    if (pop) begin
                        pay_cnt_q <= pay_cnt_q - flit_t'(1);
                        if (pay_cnt_q == flit_t'(1)) begin
                            state_q  <= S_IDLE;
                            sender_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    h_q      <= 1'b0;
                    sender_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hermes_input_buffer.sv
// Directed bench for hermes_input_buffer: reset, framing, backpressure,
// zero-size packets, upstream gaps and mid-packet reset.
module tb_hermes_input_buffer;
  import hermes_pkg::*;

  logic       clock;
  logic       reset;
  logic       rx;
  flit_t      data_in;
  logic       credit_o;
  logic       h;
  logic       ack_h;
  logic       data_av;
  flit_t      data_out;
  logic       data_ack;
  logic       sender;
  ib_state_t  dbg_state;
  logic [2:0] dbg_count;

  int tests_run;
  int tests_failed;

  hermes_input_buffer #(
    .DEPTH (4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .rx          (rx),
    .data_in     (data_in),
    .credit_o    (credit_o),
    .h           (h),
    .ack_h       (ack_h),
    .data_av     (data_av),
    .data_out    (data_out),
    .data_ack    (data_ack),
    .sender      (sender),
    .dbg_state_o (dbg_state),
    .dbg_count_o (dbg_count)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // waits (bounded) for a presented flit, checks it, and lets it pop
  task automatic expect_pop(input string tag, input logic [31:0] exp);
    int waited;
    waited = 0;
    while (!data_av && waited < 20) begin
      step();
      waited++;
    end
    check({tag, "_av"}, {31'd0, data_av}, 32'd1);
    check(tag, {16'd0, data_out}, exp);
    step();
  endtask

  initial begin
    flit_t sp_exp [4];
    flit_t bp_exp [3];
    flit_t zs_seq [5];
    flit_t rm_seq [6];
    flit_t gap_val;
    ib_state_t gap_state;

    tests_run    = 0;
    tests_failed = 0;

    // ---------------- reset ----------------
    reset    = 1'b0;
    rx       = 1'b1;
    data_in  = 16'hFFFF;
    ack_h    = 1'b0;
    data_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_credit", {31'd0, credit_o}, 32'd1);
      check("rst_h", {31'd0, h}, 32'd0);
      check("rst_data_av", {31'd0, data_av}, 32'd0);
      check("rst_sender", {31'd0, sender}, 32'd0);
      check("rst_count", {29'd0, dbg_count}, 32'd0);
    end
    check("rst_data_out", {16'd0, data_out}, 32'h0);
    reset = 1'b1;
    rx    = 1'b0;
    step();
    check("rst_count_after", {29'd0, dbg_count}, 32'd0);
    check("rst_state_after", 32'(dbg_state), 32'(S_IDLE));

    // ---------------- single packet ----------------
    sp_exp[0] = 16'h0011;
    sp_exp[1] = 16'h0002;
    sp_exp[2] = 16'hAAAA;
    sp_exp[3] = 16'hBBBB;
    data_ack = 1'b1;
    rx       = 1'b1;
    data_in  = sp_exp[0];
    step();
    check("sp_h_after_hdr_write", {31'd0, h}, 32'd0);
    data_in = sp_exp[1];
    step();
    check("sp_h_rise", {31'd0, h}, 32'd1);
    data_in = sp_exp[2];
    step();
    data_in = sp_exp[3];
    step();
    rx = 1'b0;
    check("sp_count_full", {29'd0, dbg_count}, 32'd4);
    check("sp_credit_full", {31'd0, credit_o}, 32'd0);
    step();
    check("sp_h_held", {31'd0, h}, 32'd1);
    check("sp_sender_wait", {31'd0, sender}, 32'd0);
    ack_h = 1'b1;
    step();
    ack_h = 1'b0;
    check("sp_sender_rise", {31'd0, sender}, 32'd1);
    check("sp_h_drop", {31'd0, h}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("sp_pop_av", {31'd0, data_av}, 32'd1);
      check("sp_pop_data", {16'd0, data_out}, {16'd0, sp_exp[i]});
      step();
    end
    check("sp_sender_fall", {31'd0, sender}, 32'd0);
    check("sp_state_idle", 32'(dbg_state), 32'(S_IDLE));
    check("sp_count_empty", {29'd0, dbg_count}, 32'd0);

    // ---------------- backpressure ----------------
    ack_h    = 1'b1;
    data_ack = 1'b0;
    rx       = 1'b1;
    data_in  = 16'h0055;
    step();
    data_in = 16'h0004;
    step();
    data_in = 16'h1111;
    step();
    data_in = 16'h2222;
    step();
    check("bp_credit_full", {31'd0, credit_o}, 32'd0);
    check("bp_count_4", {29'd0, dbg_count}, 32'd4);
    data_in = 16'h3333;
    step();
    check("bp_count_hold", {29'd0, dbg_count}, 32'd4);
    check("bp_credit_hold", {31'd0, credit_o}, 32'd0);
    check("bp_av_stalled", {31'd0, data_av}, 32'd1);
    check("bp_head_hdr", {16'd0, data_out}, 32'h0055);
    data_ack = 1'b1;
    ack_h    = 1'b0;
    step();
    check("bp_credit_back", {31'd0, credit_o}, 32'd1);
    check("bp_count_3", {29'd0, dbg_count}, 32'd3);
    check("bp_head_size", {16'd0, data_out}, 32'h0004);
    step();
    data_in = 16'h4444;
    check("bp_head_p1", {16'd0, data_out}, 32'h1111);
    check("bp_state_pay", 32'(dbg_state), 32'(S_PAY));
    step();
    rx = 1'b0;
    bp_exp[0] = 16'h2222;
    bp_exp[1] = 16'h3333;
    bp_exp[2] = 16'h4444;
    for (int i = 0; i < 3; i++) begin
      check("bp_tail_av", {31'd0, data_av}, 32'd1);
      check("bp_tail_data", {16'd0, data_out}, {16'd0, bp_exp[i]});
      step();
    end
    check("bp_sender_fall", {31'd0, sender}, 32'd0);
    check("bp_count_empty", {29'd0, dbg_count}, 32'd0);

    // ---------------- zero-size packet then back-to-back ----------------
    zs_seq[0] = 16'h0022;
    zs_seq[1] = 16'h0000;
    zs_seq[2] = 16'h0033;
    zs_seq[3] = 16'h0001;
    zs_seq[4] = 16'hCCCC;
    ack_h    = 1'b1;
    data_ack = 1'b1;
    rx       = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data_in = zs_seq[i];
      step();
      if (i == 2) check("zs_head_hdr", {16'd0, data_out}, 32'h0022);
      if (i == 3) check("zs_head_size", {16'd0, data_out}, 32'h0000);
    end
    rx = 1'b0;
    check("zs_end_sender_low", {31'd0, sender}, 32'd0);
    check("zs_end_state_idle", 32'(dbg_state), 32'(S_IDLE));
    step();
    check("zs_h_reassert", {31'd0, h}, 32'd1);
    check("zs_sender_gap", {31'd0, sender}, 32'd0);
    expect_pop("zs_hdr2", 32'h0033);
    expect_pop("zs_size2", 32'h0001);
    expect_pop("zs_pay2", 32'hCCCC);
    check("zs_done_idle", 32'(dbg_state), 32'(S_IDLE));

    // ---------------- upstream gaps ----------------
    rx      = 1'b1;
    data_in = 16'h0066;
    step();
    data_in = 16'h0003;
    step();
    rx = 1'b0;
    step();
    step();
    step();
    check("gap_state_pay", 32'(dbg_state), 32'(S_PAY));
    check("gap_av_empty", {31'd0, data_av}, 32'd0);
    step();
    check("gap_state_hold", 32'(dbg_state), 32'(S_PAY));
    for (int i = 0; i < 3; i++) begin
      gap_val = flit_t'(16'h7001 + i);
      gap_state = (i < 2) ? S_PAY : S_IDLE;
      rx      = 1'b1;
      data_in = gap_val;
      step();
      rx = 1'b0;
      check("gap_av_high", {31'd0, data_av}, 32'd1);
      check("gap_data", {16'd0, data_out}, {16'd0, gap_val});
      step();
      check("gap_av_low", {31'd0, data_av}, 32'd0);
      check("gap_state", 32'(dbg_state), 32'(gap_state));
    end

    // ---------------- reset mid-packet ----------------
    rm_seq[0] = 16'h0077;
    rm_seq[1] = 16'h0005;
    rm_seq[2] = 16'h8001;
    rm_seq[3] = 16'h8002;
    rm_seq[4] = 16'h8003;
    rm_seq[5] = 16'h8004;
    rx = 1'b1;
    for (int i = 0; i < 6; i++) begin
      data_in = rm_seq[i];
      step();
    end
    rx = 1'b0;
    step();
    check("rm_state_pay", 32'(dbg_state), 32'(S_PAY));
    check("rm_count_2", {29'd0, dbg_count}, 32'd2);
    check("rm_head", {16'd0, data_out}, 32'h8003);
    #2;
    reset = 1'b0;
    #1;
    check("rm_async_credit", {31'd0, credit_o}, 32'd1);
    check("rm_async_h", {31'd0, h}, 32'd0);
    check("rm_async_av", {31'd0, data_av}, 32'd0);
    check("rm_async_sender", {31'd0, sender}, 32'd0);
    check("rm_async_data", {16'd0, data_out}, 32'h0);
    check("rm_async_count", {29'd0, dbg_count}, 32'd0);
    check("rm_async_state", 32'(dbg_state), 32'(S_IDLE));
    step();
    step();
    reset = 1'b1;
    rx    = 1'b1;
    data_in = 16'h0044;
    step();
    data_in = 16'h0001;
    step();
    data_in = 16'hDDDD;
    step();
    rx = 1'b0;
    expect_pop("rm_new_hdr", 32'h0044);
    expect_pop("rm_new_size", 32'h0001);
    expect_pop("rm_new_pay", 32'hDDDD);
    check("rm_new_idle", 32'(dbg_state), 32'(S_IDLE));
    check("rm_new_sender", {31'd0, sender}, 32'd0);
    check("rm_new_count", {29'd0, dbg_count}, 32'd0);

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
